// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the memory port arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_e;

  // Which requester owns the transaction currently on the memory port.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Counter widths sized for MAX_DM_RUN = 4 and TIMEOUT = 255.
  localparam int DM_RUN_W = 3;
  localparam int WD_W     = 8;

  function automatic logic owner_of(input arb_state_e s);
    return (s == DM_BUSY) ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Purpose: counts busy cycles of a bus transaction and flags one that has hung.
// Latency: expire is combinational in the LIMIT-th enabled cycle after clr.
// Backpressure: none; it only observes, the owning master decides what to abort.
module arb_watchdog #(
  parameter int LIMIT = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = en & (cnt_q == CNT_W'(LIMIT - 1));

  // Restart on each new transaction, otherwise count busy cycles and park at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en & ~expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch and the MEM stage, data first.
// Latency: request in cycle N, mem_req in N+1, done the cycle after mem_ack (min N+2).
// Backpressure: requesters hold req until done; stall_f/stall_m freeze the pipeline meanwhile.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_sb,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  arb_state_e          state_q, state_d;
  logic [DM_RUN_W-1:0] dm_run_q, dm_run_d;
  logic                discard_q, discard_d;
  logic                if_done_q, if_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_sb_q, mem_sb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                bus_err_q, bus_err_d;

  logic grant_dm, grant_if, busy, ack_v, wd_expire, finish, timed_out;
  logic unused_if_addr;

  // Fetch is word aligned; the low address bits carry no information.
  assign unused_if_addr = ^if_addr[1:0];

  // Acks are only meaningful while a request is outstanding.
  assign busy      = (state_q != IDLE);
  assign ack_v     = mem_ack & mem_req_q;
  assign timed_out = busy & wd_expire & ~ack_v;
  assign finish    = busy & (ack_v | wd_expire);

  arb_watchdog #(
    .LIMIT (TIMEOUT),
    .CNT_W (WD_W)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (grant_dm | grant_if),
    .en     (busy),
    .expire (wd_expire)
  );

  // IDLE arbitration: data wins unless fetch has already waited MAX_DM_RUN grants.
  always_comb begin
    grant_dm = (state_q == IDLE) & dm_req &
               (~if_req | (dm_run_q < DM_RUN_W'(MAX_DM_RUN)));
    grant_if = (state_q == IDLE) & ~grant_dm & if_req & ~if_flush;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = DM_BUSY;
        else if (grant_if) state_d = IF_BUSY;
      end
      default: begin
        if (finish) state_d = IDLE;
      end
    endcase
  end

  // Datapath registers, done pulses, starvation counter and flush bookkeeping.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_sb_d    = mem_sb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = bus_err_q | timed_out;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;

    if (grant_dm) begin
      mem_req_d   = 1'b1;
      mem_sb_d    = dm_sb;
      mem_we_d    = dm_we & ~dm_sb;   // byte store takes precedence over word store
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
    end else if (grant_if) begin
      mem_req_d   = 1'b1;
      mem_sb_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
    end

    if (finish) begin
      mem_req_d = 1'b0;
      if (owner_of(state_q) == OWN_IF) begin
        // A flush seen at any point of the fetch drops its result silently.
        if (~discard_q & ~if_flush) begin
          if_done_d  = 1'b1;
          if_rdata_d = timed_out ? '0 : mem_rdata;
        end
      end else begin
        dm_done_d = 1'b1;
        if (timed_out)                  dm_rdata_d = '0;
        else if (~mem_we_q & ~mem_sb_q) dm_rdata_d = mem_rdata;
      end
    end

    discard_d = (state_d == IF_BUSY) & (discard_q | if_flush);

    if (~if_req | grant_if) begin
      dm_run_d = '0;
    end else if (grant_dm & (dm_run_q < DM_RUN_W'(MAX_DM_RUN))) begin
      dm_run_d = dm_run_q + DM_RUN_W'(1);
    end else begin
      dm_run_d = dm_run_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dm_run_q    <= '0;
      discard_q   <= 1'b0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sb_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dm_run_q    <= dm_run_d;
      discard_q   <= discard_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_done_q   <= dm_done_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_sb_q    <= mem_sb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // A redirect arriving in the done cycle still hides the now-stale instruction.
  assign if_done   = if_done_q & ~if_flush;
  assign if_rdata  = if_rdata_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_f   = if_req & ~if_done;
  assign stall_m   = dm_req & ~dm_done;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_sb    = mem_sb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_sb, dm_done;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        stall_f, stall_m;
  logic        mem_req, mem_we, mem_sb, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_sb     (dm_sb),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .stall_f   (stall_f),
    .stall_m   (stall_m),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sb    (mem_sb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " if_done"},   {31'd0, if_done},   32'd0);
    chk({tag, " if_rdata"},  if_rdata,           32'd0);
    chk({tag, " dm_done"},   {31'd0, dm_done},   32'd0);
    chk({tag, " dm_rdata"},  dm_rdata,           32'd0);
    chk({tag, " mem_req"},   {31'd0, mem_req},   32'd0);
    chk({tag, " mem_we"},    {31'd0, mem_we},    32'd0);
    chk({tag, " mem_sb"},    {31'd0, mem_sb},    32'd0);
    chk({tag, " mem_addr"},  mem_addr,           32'd0);
    chk({tag, " mem_wdata"}, mem_wdata,          32'd0);
    chk({tag, " bus_err"},   {31'd0, bus_err},   32'd0);
  endtask

  initial begin
    logic [31:0] seen[$];

    rst_n = 1'b0; if_req = 0; if_flush = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_sb = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    chk_all_zero("reset");
    chk("reset stall_f", {31'd0, stall_f}, 32'd0);
    chk("reset stall_m", {31'd0, stall_m}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Fetch only: low address bits are dropped on the memory side.
    if_req = 1; if_addr = 32'h0040_0002; #1;
    chk("f1 stall_f N", {31'd0, stall_f}, 32'd1);
    chk("f1 mem_req N", {31'd0, mem_req}, 32'd0);
    tick();
    chk("f1 mem_req N+1", {31'd0, mem_req}, 32'd1);
    chk("f1 mem_addr", mem_addr, 32'h0040_0000);
    chk("f1 mem_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1; mem_rdata = 32'h2008_0005; #1;
    chk("f1 stall_f N+1", {31'd0, stall_f}, 32'd1);
    tick();
    chk("f1 if_done", {31'd0, if_done}, 32'd1);
    chk("f1 if_rdata", if_rdata, 32'h2008_0005);
    chk("f1 mem_req off", {31'd0, mem_req}, 32'd0);
    chk("f1 stall_f N+2", {31'd0, stall_f}, 32'd0);
    if_req = 0;
    tick();
    chk("f1 if_done one pulse", {31'd0, if_done}, 32'd0);
    // Stray ack while idle is ignored (mem_ack still high from above).
    tick();
    chk("stray dm_done", {31'd0, dm_done}, 32'd0);
    chk("stray if_done", {31'd0, if_done}, 32'd0);
    chk("stray mem_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 0;

    // Collision: data first, fetch granted in the dm_done cycle.
    if_req = 1; if_addr = 32'h0040_0004;
    dm_req = 1; dm_we = 0; dm_addr = 32'h1000_0004;
    tick();
    chk("col mem_addr dm", mem_addr, 32'h1000_0004);
    chk("col mem_req dm", {31'd0, mem_req}, 32'd1);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick();
    chk("col dm_done", {31'd0, dm_done}, 32'd1);
    chk("col dm_rdata", dm_rdata, 32'h1234_5678);
    chk("col if_done early", {31'd0, if_done}, 32'd0);
    chk("col mem_req gap", {31'd0, mem_req}, 32'd0);
    dm_req = 0; mem_ack = 0;
    tick();
    chk("col mem_req if", {31'd0, mem_req}, 32'd1);
    chk("col mem_addr if", mem_addr, 32'h0040_0004);
    mem_ack = 1; mem_rdata = 32'h0000_0013;
    tick();
    chk("col if_done", {31'd0, if_done}, 32'd1);
    chk("col if_rdata", if_rdata, 32'h0000_0013);
    if_req = 0; mem_ack = 0;
    tick();

    // Starvation: four data grants, one fetch, then four data again.
    dm_req = 1; dm_we = 0; dm_addr = 32'h1000_0008;
    if_req = 1; if_addr = 32'h0040_0008;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req) seen.push_back(mem_addr);
      mem_ack = mem_req;
    end
    dm_req = 0; if_req = 0; mem_ack = 0;
    chk("starve grant count", seen.size(), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("starve grant %0d", k), (k < seen.size()) ? seen[k] : 32'hFFFF_FFFF,
          (k == 4 || k == 9) ? 32'h0040_0008 : 32'h1000_0008);
    end
    tick(); tick();

    // Flush during a fetch: result dropped, next fetch granted right after.
    if_req = 1; if_addr = 32'h0040_0010;
    tick();
    chk("fl mem_req", {31'd0, mem_req}, 32'd1);
    if_flush = 1;
    tick();
    if_flush = 0;
    tick(); tick();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("fl if_done dropped", {31'd0, if_done}, 32'd0);
    chk("fl if_rdata kept", if_rdata, 32'h0000_0013);
    mem_ack = 0;
    tick();
    chk("fl refetch mem_req", {31'd0, mem_req}, 32'd1);
    chk("fl refetch addr", mem_addr, 32'h0040_0010);
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    tick();
    chk("fl refetch if_done", {31'd0, if_done}, 32'd1);
    chk("fl refetch if_rdata", if_rdata, 32'h0050_0093);
    if_req = 0; mem_ack = 0;
    tick();

    // Fetch request with flush in the same idle cycle is not granted.
    if_req = 1; if_flush = 1; if_addr = 32'h0040_0014;
    tick();
    chk("idle flush no grant", {31'd0, mem_req}, 32'd0);
    if_req = 0; if_flush = 0;
    tick();

    // Store byte with dm_we also set: byte write wins, fields held until ack.
    dm_req = 1; dm_sb = 1; dm_we = 1; dm_addr = 32'h1000_0003; dm_wdata = 32'h0000_00A5;
    tick();
    chk("sb mem_sb", {31'd0, mem_sb}, 32'd1);
    chk("sb mem_we", {31'd0, mem_we}, 32'd0);
    chk("sb mem_addr", mem_addr, 32'h1000_0003);
    tick();
    chk("sb held mem_req", {31'd0, mem_req}, 32'd1);
    chk("sb held mem_wdata", mem_wdata, 32'h0000_00A5);
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("sb dm_done", {31'd0, dm_done}, 32'd1);
    chk("sb dm_rdata kept", dm_rdata, 32'h0000_0013);
    dm_req = 0; dm_sb = 0; dm_we = 0; mem_ack = 0;
    tick();

    // Timeout: 255 busy cycles without ack, then abort with rdata 0.
    dm_req = 1; dm_addr = 32'h1000_0010;
    for (int i = 0; i < 255; i++) tick();
    chk("to still busy", {31'd0, mem_req}, 32'd1);
    chk("to no err yet", {31'd0, bus_err}, 32'd0);
    chk("to no done yet", {31'd0, dm_done}, 32'd0);
    tick();
    chk("to dm_done", {31'd0, dm_done}, 32'd1);
    chk("to dm_rdata", dm_rdata, 32'd0);
    chk("to bus_err", {31'd0, bus_err}, 32'd1);
    chk("to mem_req off", {31'd0, mem_req}, 32'd0);
    dm_req = 0;
    tick();
    chk("to bus_err sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of a fetch.
    if_req = 1; if_addr = 32'h0040_0020;
    tick();
    chk("rst pre mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 0;
    tick();
    if_req = 0;
    chk_all_zero("midrst");
    rst_n = 1; if_req = 1;
    tick();
    chk("post rst grant", {31'd0, mem_req}, 32'd1);
    chk("post rst addr", mem_addr, 32'h0040_0020);
    mem_ack = 1; mem_rdata = 32'h0000_0067;
    tick();
    chk("post rst if_done", {31'd0, if_done}, 32'd1);
    chk("post rst if_rdata", if_rdata, 32'h0000_0067);
    if_req = 0; mem_ack = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
